// File: rtl/periph_arbiter.sv
// periph_arbiter: two-requester round-robin arbiter in front of a shared
// peripheral bus. The winning requester's device/command/data are broadcast,
// a one-cycle perform strobe is issued, and the arbiter waits for the
// peripherals to go idle (or for TIMEOUT cycles) before acknowledging.
module periph_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255  // legal range 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [4:0]  dev0,
  input  logic [5:0]  cmd0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [4:0]  dev1,
  input  logic [5:0]  cmd1,
  input  logic [31:0] data1,
  input  logic        periph_busy,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [4:0]  device,
  output logic [5:0]  command,
  output logic [31:0] data_out,
  output logic        perf_en,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;        // cycles spent in WAIT with peripherals busy
  logic        grant_q, grant_d;    // requester owning the current transaction
  logic        last_q, last_d;      // requester granted most recently
  logic        err_q, err_d;        // current transaction ended by timeout
  logic [4:0]  device_q, device_d;
  logic [5:0]  command_q, command_d;
  logic [31:0] data_q, data_d;
  logic        winner;

  // Round-robin choice: on contention the requester not granted last wins;
  // a lone request always wins.
  always_comb begin
    if (req0 && req1) winner = ~last_q;
    else              winner = req1;
  end

  // Next-state logic and Moore outputs decoded from the registered state.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise an
    // unassigned path through the case statement infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    err_d     = err_q;
    device_d  = device_q;
    command_d = command_q;
    data_d    = data_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_d = winner;
          if (winner) begin
            device_d  = dev1;
            command_d = cmd1;
            data_d    = data1;
          end else begin
            device_d  = dev0;
            command_d = cmd0;
            data_d    = data0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!periph_busy) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT) begin
          // TIMEOUT never exceeds 255, so the 8-bit counter cannot wrap.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    perf_en  = (state_q == S_ISSUE);
    busy     = (state_q != S_IDLE);
    ack0     = (state_q == S_DONE) && !grant_q;
    ack1     = (state_q == S_DONE) &&  grant_q;
    err      = (state_q == S_DONE) &&  err_q;
    device   = device_q;
    command  = command_q;
    data_out = data_q;
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: last_q resets to 1 so that requester 0 wins the first contention;
      // all broadcast registers are cleared so outputs read 0 during reset.
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      device_q  <= 5'd0;
      command_q <= 6'd0;
      data_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      err_q     <= err_d;
      device_q  <= device_d;
      command_q <= command_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_periph_arbiter.sv
// Self-checking bench for periph_arbiter: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_periph_arbiter;

  localparam logic [7:0] TO = 8'd4;

  localparam logic [42:0] PA = {5'd0, 6'd1, 32'h0000_00A5};
  localparam logic [42:0] PB = {5'd3, 6'd2, 32'h0000_0011};
  localparam logic [42:0] PC = {5'd7, 6'd5, 32'h0000_0022};

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, periph_busy;
  logic [4:0]  dev0, dev1;
  logic [5:0]  cmd0, cmd1;
  logic [31:0] data0, data1;
  logic        ack0, ack1, err, perf_en, busy;
  logic [4:0]  device;
  logic [5:0]  command;
  logic [31:0] data_out;
  logic [47:0] outs;

  always #5 clk = ~clk;

  periph_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .dev0(dev0), .cmd0(cmd0), .data0(data0),
    .req1(req1), .dev1(dev1), .cmd1(cmd1), .data1(data1),
    .periph_busy(periph_busy),
    .ack0(ack0), .ack1(ack1), .err(err),
    .device(device), .command(command), .data_out(data_out),
    .perf_en(perf_en), .busy(busy)
  );

  // {ack0, ack1, err, perf_en, busy, device, command, data_out}
  assign outs = {ack0, ack1, err, perf_en, busy, device, command, data_out};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {req0, req1, periph_busy} = 3'b000;
    {dev0, cmd0, data0} = 43'd0;
    {dev1, cmd1, data1} = 43'd0;
    tick();
    tick();
    check("reset_outputs", outs, 48'd0);
    reset = 1'b0;
  endtask

  // stim = {req0, req1, periph_busy, requester-0 payload B (else A)}
  typedef struct {
    logic [3:0]  stim;
    logic [47:0] exp;
  } vec_t;

  vec_t tbl [14];

  // transaction-level reference model state
  bit          m_active, m_win, m_last, m_err;
  longint      t_grant, t_ack;
  logic [42:0] m_pay;
  logic [47:0] m_exp;
  logic [4:0]  ctl;

  initial begin
    tbl[0]  = '{4'b1000, {5'b00000, 43'd0}};
    tbl[1]  = '{4'b0000, {5'b00011, PA}};
    tbl[2]  = '{4'b0000, {5'b00001, PA}};
    tbl[3]  = '{4'b0000, {5'b10001, PA}};
    tbl[4]  = '{4'b1101, {5'b00000, PA}};
    tbl[5]  = '{4'b1101, {5'b00011, PC}};
    tbl[6]  = '{4'b1101, {5'b00001, PC}};
    tbl[7]  = '{4'b1101, {5'b01001, PC}};
    tbl[8]  = '{4'b1101, {5'b00000, PC}};
    tbl[9]  = '{4'b1101, {5'b00011, PB}};
    tbl[10] = '{4'b1111, {5'b00001, PB}};
    tbl[11] = '{4'b1101, {5'b00001, PB}};
    tbl[12] = '{4'b0001, {5'b10001, PB}};
    tbl[13] = '{4'b0001, {5'b00000, PB}};

    // Directed table: single request, contention, busy-extended wait.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      check($sformatf("vec%0d", i), outs, tbl[i].exp);
      {req0, req1, periph_busy} = tbl[i].stim[3:1];
      {dev0, cmd0, data0} = tbl[i].stim[0] ? PB : PA;
      {dev1, cmd1, data1} = PC;
      tick();
    end

    // Both requesters held from reset release: grants alternate 0,1,0,1.
    do_reset();
    {dev0, cmd0, data0} = {5'd1, 6'd0, 32'd0};
    {dev1, cmd1, data1} = {5'd2, 6'd0, 32'd0};
    req0 = 1'b1; req1 = 1'b1; periph_busy = 1'b0;
    for (int c = 0; c < 16; c++) begin
      int ph;
      int g;
      ph  = c % 4;
      g   = (c / 4) % 2;
      ctl = {ph == 3 && g == 0, ph == 3 && g == 1, 1'b0, ph == 1, ph != 0};
      check($sformatf("rr_c%0d", c), {43'd0, outs[47:43]}, {43'd0, ctl});
      if (ph == 1) check($sformatf("rr_dev_c%0d", c), {43'd0, device}, (g == 1) ? 48'd2 : 48'd1);
      if (c == 15) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
    end

    // req1 with peripherals busy for 3 WAIT cycles, request dropped during WAIT.
    for (int c = 0; c < 9; c++) begin
      ctl = {1'b0, c == 6, 1'b0, c == 1, c >= 1 && c <= 6};
      check($sformatf("wait3_c%0d", c), {43'd0, outs[47:43]}, {43'd0, ctl});
      req1 = (c <= 1);
      periph_busy = (c >= 2 && c <= 4);
      tick();
    end

    // Timeout: periph_busy stuck high, req0 dropped during WAIT.
    for (int c = 0; c < 10; c++) begin
      ctl = {c == 7, 1'b0, c == 7, c == 1, c >= 1 && c <= 7};
      check($sformatf("timeout_c%0d", c), {43'd0, outs[47:43]}, {43'd0, ctl});
      req0 = (c <= 2);
      periph_busy = 1'b1;
      tick();
    end
    periph_busy = 1'b0;

    // Reset pulsed during WAIT aborts with no ack; next request runs normally.
    req0 = 1'b1; {dev0, cmd0, data0} = {5'd5, 6'd3, 32'h77}; periph_busy = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    check("pre_rst_wait", {43'd0, outs[47:43]}, {43'd0, 5'b00001});
    reset = 1'b1;
    #1;
    check("rst_mid_wait", outs, 48'd0);
    tick();
    check("rst_held", outs, 48'd0);
    reset = 1'b0;
    periph_busy = 1'b0;
    check("post_rst_idle", outs, 48'd0);
    req0 = 1'b1;
    tick();
    check("post_rst_issue", outs, {5'b00011, 5'd5, 6'd3, 32'h77});
    req0 = 1'b0;
    tick();
    check("post_rst_wait", outs, {5'b00001, 5'd5, 6'd3, 32'h77});
    tick();
    check("post_rst_done", outs, {5'b10001, 5'd5, 6'd3, 32'h77});
    tick();
    check("post_rst_idle2", outs, {5'b00000, 5'd5, 6'd3, 32'h77});

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_active = 1'b0; m_last = 1'b1; m_err = 1'b0; m_win = 1'b0;
    m_pay = 43'd0; t_grant = 0; t_ack = -1;
    for (longint t = 0; t < 3000; t++) begin
      m_exp = {m_active && t == t_ack && !m_win,
               m_active && t == t_ack &&  m_win,
               m_active && t == t_ack &&  m_err,
               m_active && t == t_grant + 1,
               m_active,
               m_pay};
      check($sformatf("rand_t%0d", t), outs, m_exp);

      req0        = ($urandom % 3) != 0;
      req1        = ($urandom % 3) != 0;
      periph_busy = ($urandom % 4) != 0;
      dev0 = 5'($urandom); cmd0 = 6'($urandom); data0 = $urandom;
      dev1 = 5'($urandom); cmd1 = 6'($urandom); data1 = $urandom;

      // Grant -> perform one cycle later -> waits from grant+2 until the
      // bus goes idle or TIMEOUT busy cycles have been counted -> ack.
      if (!m_active) begin
        if (req0 || req1) begin
          m_win    = (req0 && req1) ? !m_last : req1;
          m_pay    = m_win ? {dev1, cmd1, data1} : {dev0, cmd0, data0};
          m_active = 1'b1;
          t_grant  = t;
          t_ack    = -1;
        end
      end else if (t == t_ack) begin
        m_last   = m_win;
        m_active = 1'b0;
      end else if (t >= t_grant + 2 && t_ack < 0) begin
        if (!periph_busy || (t - t_grant - 2) == longint'(TO)) begin
          t_ack = t + 1;
          m_err = periph_busy;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 8'd255, maximum cycles spent in WAIT before forced completion; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 (CPU) transaction request, level.
REQ-005 dev0  input  5  requester 0 target device number.
REQ-006 cmd0  input  6  requester 0 command code.
REQ-007 data0  input  32  requester 0 write data.
REQ-008 req1  input  1  requester 1 (debug port) transaction request, level.
REQ-009 dev1  input  5  requester 1 target device number.
REQ-010 cmd1  input  6  requester 1 command code.
REQ-011 data1  input  32  requester 1 write data.
REQ-012 ack0  output  1  one-cycle completion pulse to requester 0.
REQ-013 ack1  output  1  one-cycle completion pulse to requester 1.
REQ-014 err  output  1  valid with ack0/ack1; 1 = completed by timeout.
REQ-015 device  output  5  device number broadcast to peripherals.
REQ-016 command  output  6  command code broadcast to peripherals.
REQ-017 data_out  output  32  write data broadcast to peripherals.
REQ-018 perf_en  output  1  one-cycle perform strobe to peripherals.
REQ-019 periph_busy  input  1  OR of peripheral busy flags; 0 = addressed peripheral finished.
REQ-020 busy  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-021 FSM shall have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: no request -> stay; any req asserted -> select winner, latch winner dev/cmd/data into device/command/data_out, go ISSUE.
REQ-023 Arbitration shall be round-robin: when both req0 and req1 are high, the requester not granted most recently wins; single request always wins.
REQ-024 Round-robin pointer shall update only in DONE, marking the completed requester as most recently granted.
REQ-025 ISSUE: perf_en=1 for exactly this one cycle; go WAIT; wait counter cleared to 0.
REQ-026 WAIT: periph_busy=0 -> go DONE, err=0; else counter increments; counter == TIMEOUT with periph_busy=1 -> go DONE with err=1.
REQ-027 DONE: assert ack of granted requester only, for one cycle, with err valid; go IDLE.
REQ-028 Latency: req seen in IDLE at cycle N -> perf_en at N+1 -> earliest ack at N+3 (periph_busy=0 at N+2).
REQ-029 Timeout latency: periph_busy stuck high -> ack with err=1 at N+3+TIMEOUT.
REQ-030 device/command/data_out shall hold last latched values at all times outside IDLE-latch cycles; they change only on grant.
REQ-031 Requests sampled only in IDLE; req changes during ISSUE/WAIT/DONE ignored.
REQ-032 Requester deasserting req before ack: transaction still completes and ack still pulses.
REQ-033 Requester holding req high after ack: arbitrated again in next IDLE cycle (back-to-back issue every 4 cycles minimum).
REQ-034 ack0 and ack1 shall never be high in the same cycle; perf_en never high outside ISSUE.
REQ-035 Wait counter shall be 8 bits and shall not wrap (TIMEOUT ≤ 255 guarantees exit).

Reset
REQ-036 reset=1 shall immediately force state IDLE, ack0=ack1=err=perf_en=busy=0, device=0, command=0, data_out=0, counter=0, pointer = requester 0 preferred.
REQ-037 Reset mid-transaction shall abort with no ack; first request after release is arbitrated from IDLE.

Verification
REQ-038 req0=1, dev0=0, cmd0=6'b000001, data0=32'h000000A5, periph_busy=0 at N -> perf_en at N+1 with device=0, command=1, data_out=A5; ack0 at N+3, err=0.
REQ-039 req0 and req1 both held high from reset release -> grants alternate 0,1,0,1; ack0/ack1 pulses 4 cycles apart.
REQ-040 req1=1, periph_busy high 3 cycles after perf_en -> ack1 exactly 3 cycles later than zero-wait case, err=0.
REQ-041 TIMEOUT=4, periph_busy stuck high -> ack at N+7, err=1; FSM back in IDLE next cycle.
REQ-042 reset pulsed during WAIT -> no ack, all outputs 0, next req0 yields normal perf_en at +1 cycle.
REQ-043 req0 dropped during WAIT -> ack0 still pulses; no second perf_en issued.
